// File: rtl/debouncer_multi_pkg.sv
// rtl/debouncer_multi_pkg.sv - shared constants and counter sizing for the debouncer
package debouncer_multi_pkg;

  localparam logic DEFAULT_RESET_LEVEL = 1'b0;

  // Counter width for a STABLE_TICKS window, never narrower than one bit.
  function automatic int cnt_width(input int ticks);
    int w;
    w = $clog2(ticks);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debouncer_multi_channel.sv
// rtl/debouncer_multi_channel.sv - one channel: synchroniser, stability counter, level/strobe flops
module debounce_channel
  import debouncer_multi_pkg::*;
#(
  parameter int   STABLE_TICKS = 500,
  parameter logic RESET_LEVEL  = DEFAULT_RESET_LEVEL,
  parameter int   SYNC_STAGES  = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clken,
  input  logic i_in,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_accept
);

  localparam int               CNT_W   = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;
  logic                   w_accept;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_accept = i_clken && (w_s != r_level) && (r_cnt == CNT_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= {SYNC_STAGES{RESET_LEVEL}};
      r_cnt   <= '0;
      r_level <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      r_rise <= w_accept & w_s;
      r_fall <= w_accept & ~w_s;
      // Any sample matching the current level restarts the stability window.
      if (i_clken) begin
        if (w_s == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_level <= w_s;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_level  = r_level;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_accept = w_accept;

endmodule

// File: rtl/debouncer_multi.sv
// rtl/debouncer_multi.sv - N-channel switch debouncer with per-channel rise/fall strobes
module debouncer_multi
  import debouncer_multi_pkg::*;
#(
  parameter int   CHANNELS     = 4,
  parameter int   STABLE_TICKS = 500,
  parameter logic RESET_LEVEL  = DEFAULT_RESET_LEVEL,
  parameter int   SYNC_STAGES  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clken,
  input  logic [CHANNELS-1:0] i_in,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic                o_any_chg
);

  logic [CHANNELS-1:0] w_accept;
  logic                r_any_chg;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_LEVEL (RESET_LEVEL),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clken (i_clken),
      .i_in    (i_in[g]),
      .o_level (o_level[g]),
      .o_rise  (o_rise[g]),
      .o_fall  (o_fall[g]),
      .o_accept(w_accept[g])
    );
  end

  // Built from next-state acceptances so it lands on the same edge as the strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_any_chg <= 1'b0;
    end else begin
      r_any_chg <= |w_accept;
    end
  end

  assign o_any_chg = r_any_chg;

endmodule

// File: tb/tb_debouncer_multi.sv
// tb/tb_debouncer_multi.sv - directed self-checking bench for debouncer_multi
module tb_debouncer_multi;

  logic       clk;
  logic       rst_n;
  logic       clken;
  logic [3:0] in_v;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       any_chg;

  int n_checks = 0;
  int n_fail   = 0;

  debouncer_multi #(
    .CHANNELS    (4),
    .STABLE_TICKS(4),
    .RESET_LEVEL (1'b0),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_clken  (clken),
    .i_in     (in_v),
    .o_level  (level),
    .o_rise   (rise),
    .o_fall   (fall),
    .o_any_chg(any_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int seen;
    int chg_cnt;

    rst_n = 1'b0;
    clken = 1'b1;
    in_v  = 4'b0000;
    tick(2);
    check("reset_level",  level,   4'b0000);
    check("reset_rise",   rise,    4'b0000);
    check("reset_fall",   fall,    4'b0000);
    check("reset_anychg", any_chg, 1'b0);
    rst_n = 1'b1;
    tick(3);

    // 1. clean press on ch0: accepted after edge 5
    in_v = 4'b0001;
    tick(5);
    check("t1_level_early", level, 4'b0000);
    tick(1);
    check("t1_level", level,   4'b0001);
    check("t1_rise",  rise,    4'b0001);
    check("t1_fall",  fall,    4'b0000);
    check("t1_any",   any_chg, 1'b1);
    tick(1);
    check("t1_rise_off", rise,    4'b0000);
    check("t1_any_off",  any_chg, 1'b0);
    check("t1_hold",     level,   4'b0001);

    // 2. bounce on ch1, final 0->1 then held
    in_v[1] = 1'b1; tick(1);
    in_v[1] = 1'b0; tick(1);
    in_v[1] = 1'b1; tick(1);
    in_v[1] = 1'b0; tick(1);
    in_v[1] = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (rise[1] || any_chg) seen++;
    end
    check("t2_no_early_rise", seen, 0);
    tick(1);
    check("t2_rise",  rise,  4'b0010);
    check("t2_level", level, 4'b0011);

    // 3. release on ch2
    in_v[2] = 1'b1;
    tick(7);
    check("t3_level_hi", level, 4'b0111);
    in_v[2] = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (rise[2] || fall[2]) seen++;
    end
    check("t3_no_early", seen, 0);
    tick(1);
    check("t3_fall",  fall,  4'b0100);
    check("t3_rise",  rise,  4'b0000);
    check("t3_level", level, 4'b0011);
    tick(1);
    check("t3_fall_off", fall, 4'b0000);

    // 4. clken only on edges 2,5,8,11 -> accept at edge 11
    in_v[3] = 1'b1;
    for (int e = 0; e < 12; e++) begin
      clken = (e % 3 == 2);
      tick(1);
      if (e == 10) check("t4_level_early", level, 4'b0011);
    end
    check("t4_level", level, 4'b1011);
    check("t4_rise",  rise,  4'b1000);
    clken = 1'b1;
    tick(1);
    check("t4_rise_off", rise, 4'b0000);

    // 5. simultaneous rise on ch0 and ch3
    in_v = 4'b0010;
    tick(8);
    check("t5_lowered", level, 4'b0010);
    in_v = 4'b1011;
    chg_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (any_chg) chg_cnt++;
    end
    tick(1);
    check("t5_rise",  rise,    4'b1001);
    check("t5_any",   any_chg, 1'b1);
    if (any_chg) chg_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (any_chg) chg_cnt++;
    end
    check("t5_any_once", chg_cnt, 1);

    // 6. async reset with ch0 at cnt=2; a full window is needed afterwards
    in_v = 4'b0010;
    tick(8);
    check("t6_pre", level, 4'b0010);
    in_v = 4'b0011;
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_level", level, 4'b0000);
    check("t6_rst_rise",  rise,  4'b0000);
    tick(1);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (level != 4'b0000 || rise != 4'b0000 || fall != 4'b0000) seen++;
    end
    check("t6_no_early", seen, 0);
    tick(1);
    check("t6_level", level, 4'b0011);
    check("t6_rise",  rise,  4'b0011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
